mimo_dsp_sched: RTL
===================

Name: mimo_dsp_sched

Overview:
- Round-robin scheduler that shares one N-lane MIMO DSP engine between M requesters.
- The engine has registered lanes, each computing lane+1 mod 2^DATA_WIDTH, with fixed latency DSP_LAT.
- Accepts vector jobs over per-requester valid/ready, issues at most one per cycle to the engine, and tracks the requester ID through the engine latency.
- Returns each result to its owner through a per-requester response holding register with valid/ready.

Parameters:
- M, 4, number of requesters (>=2).
- N, 4, lanes per vector.
- DATA_WIDTH, 16, bits per lane.
- DSP_LAT, 1, engine latency in cycles from dsp_in to dsp_out (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  M  requester i has a job.
- req_ready  out  M  job from requester i accepted this cycle.
- req_data  in  M*N*DATA_WIDTH  requester i vector at slice [i*N*DATA_WIDTH +: N*DATA_WIDTH].
- resp_valid  out  M  result held for requester i.
- resp_ready  in  M  requester i takes its result.
- resp_data  out  M*N*DATA_WIDTH  result for requester i, same slicing as req_data.
- dsp_in  out  N*DATA_WIDTH  vector driven to the engine.
- dsp_out  in  N*DATA_WIDTH  engine result, valid DSP_LAT cycles after dsp_in.
- busy  out  1  any job in flight or any resp_valid set.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_data=0, dsp_in=0, busy=0. All in-flight tags are cleared and the RR pointer is set to M-1, so requester 0 has first priority.
- Per-requester slot: slot_busy[i] is set at acceptance and cleared on the cycle after resp_valid[i]&&resp_ready[i]. At most one job per requester is outstanding.
- Eligibility: req_valid[i] && !slot_busy[i].
- Arbitration:
  - Combinational one-hot grant among eligible requesters; the search starts at pointer+1 mod M.
  - req_ready = grant, so req_ready[i] is never set without req_valid[i].
  - The pointer updates to the granted index only on acceptance and holds otherwise.
- Issue stage:
  - On acceptance, dsp_in <= req_data slice of the winner, and tag pipe stage0 <= {1, winner index}.
  - With no acceptance, dsp_in holds its value (no toggle) and stage0 valid <= 0.
- Tag pipe: DSP_LAT further register stages align the tag with dsp_out.
- Capture: when the final tag stage is valid, resp_data[tag] <= dsp_out and resp_valid[tag] <= 1.
- Latency: handshake in cycle t gives dsp_in valid from t+1, dsp_out from t+1+DSP_LAT, and resp_valid from t+2+DSP_LAT (t+3 at default).
- Response hold: resp_valid[i] and resp_data[i] stay stable until resp_ready[i]. The clear takes effect on the next edge, and the requester is eligible again in the cycle after that handshake.
- Capture cannot collide with a held response: slot_busy prevents a second outstanding job per requester.
- Throughput: one issue per cycle across requesters. A single requester is limited to one job per DSP_LAT+3 cycles when resp_ready=1.
- Arithmetic: the scheduler never modifies data. Lane wrap (0xFFFF -> 0x0000) comes from the engine.
- Mid-operation reset: in-flight jobs and held results are discarded with no late resp_valid. dsp_out is ignored during reset.
- busy = OR(slot_busy), registered state only.

Decomposition:
- Shared package mimo_dsp_pkg holds DSP_LAT, the lane and vector width constants, and the tag type {valid, index [$clog2(M)-1:0]}.
- One sub-module, rr_arbiter (M-wide request vector, pointer register, one-hot grant, advance-on-accept input), reusable by other shared resources.

Test Plan:
- Single job: req 0 data lanes {4,3,2,1}. Acceptance at t; dsp_in={4,3,2,1} at t+1; resp_valid[0] at t+3 with resp_data[0] lanes {5,4,3,2}; busy falls 1 cycle after the resp handshake.
- Simultaneous: all 4 valid on the first cycle after reset -> grants 0,1,2,3 on consecutive cycles; resp_valid rises in the same order one cycle apart.
- Wrap: lanes {0xFFFF,0x7FFF,0,0x1234} -> {0x0000,0x8000,1,0x1235}.
- Backpressure: resp_ready[1]=0 for 10 cycles with req_valid[1]=1 held:
  - resp_data[1] stays stable and req_ready[1]=0 throughout.
  - Requesters 0, 2 and 3 keep being served.
  - After resp_ready[1]=1, req_ready[1] rises 2 cycles later.
- Reset mid-flight: rst asserted 1 cycle after acceptance for req 2 -> outputs 0, no resp_valid[2] afterwards; the first grant after release goes to req 0.
- Fairness: req 0 and req 2 continuously valid, resp_ready all 1 -> the grant sequence alternates 0,2,0,2 when both are eligible, and no requester starves over 100 cycles.

Source files
------------

// File: rtl/mimo_dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mimo_dsp_pkg
//  Description : Shared constants and tag type for the MIMO DSP scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package mimo_dsp_pkg;

   localparam int M          = 4;    // requesters sharing the engine
   localparam int N          = 4;    // lanes per vector
   localparam int DATA_WIDTH = 16;   // bits per lane
   localparam int DSP_LAT    = 1;    // engine latency, dsp_in -> dsp_out

   localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
   localparam int VEC_W = N * DATA_WIDTH;
   localparam int BUS_W = M * VEC_W;

   // Owner tag that travels alongside a job through the engine latency
   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tag_t;

   localparam tag_t TAG_IDLE = '{valid: 1'b0, idx: '0};

endpackage
`default_nettype wire

// File: rtl/mimo_dsp_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mimo_dsp_sched_if
//  Description : Requester, response and engine bus of the MIMO DSP scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
interface mimo_dsp_sched_if;
   import mimo_dsp_pkg::*;

   logic [M-1:0]     req_valid;
   logic [M-1:0]     req_ready;
   logic [BUS_W-1:0] req_data;
   logic [M-1:0]     resp_valid;
   logic [M-1:0]     resp_ready;
   logic [BUS_W-1:0] resp_data;
   logic [VEC_W-1:0] dsp_in;
   logic [VEC_W-1:0] dsp_out;
   logic             busy;

   // Environment side: requesters plus the DSP engine
   modport master (
      output req_valid, req_data, resp_ready, dsp_out,
      input  req_ready, resp_valid, resp_data, dsp_in, busy
   );

   // Scheduler side
   modport slave (
      input  req_valid, req_data, resp_ready, dsp_out,
      output req_ready, resp_valid, resp_data, dsp_in, busy
   );

endinterface
`default_nettype wire

// File: rtl/mimo_dsp_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter, one-hot grant, pointer advances to the
//                granted index only when the grant is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter int WIDTH = 4,
   parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [WIDTH-1:0] i_req,
   input  wire logic             i_accept,
   output logic      [WIDTH-1:0] o_grant,
   output logic      [IDX_W-1:0] o_grant_idx,
   output logic                  o_any
);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_cand;
   logic [WIDTH-1:0] w_grant;
   logic [IDX_W-1:0] w_idx;
   logic             w_any;

   // base + off wrapped into 0..WIDTH-1 (WIDTH need not be a power of two)
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= WIDTH) s = s - WIDTH;
      return IDX_W'(s);
   endfunction

   // First requester found searching upward from the slot after the pointer
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_any   = 1'b0;
      w_cand  = '0;
      for (int k = 1; k <= WIDTH; k++) begin
         w_cand = wrap_idx(r_ptr, k);
         if (!w_any && i_req[w_cand]) begin
            w_any          = 1'b1;
            w_grant[w_cand] = 1'b1;
            w_idx          = w_cand;
         end
      end
   end

   // Pointer starts at the top so index 0 has first priority after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ptr <= IDX_W'(WIDTH - 1);
      else if (i_accept && w_any)
         r_ptr <= w_idx;
   end

   assign o_grant     = w_grant;
   assign o_grant_idx = w_idx;
   assign o_any       = w_any;

endmodule
`default_nettype wire

// File: rtl/mimo_dsp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mimo_dsp_sched
//  Description : Shares one N-lane MIMO DSP engine between M requesters with
//                round-robin issue, owner tagging through the engine latency
//                and per-requester response holding registers.
//  Revision    : 1.0  initial release
// ============================================================================
module mimo_dsp_sched
   import mimo_dsp_pkg::*;
(
   input wire logic        clk,
   input wire logic        rst,
   mimo_dsp_sched_if.slave bus
);

   logic [M-1:0]     r_slot_busy;
   logic [M-1:0]     r_resp_valid;
   logic [BUS_W-1:0] r_resp_data;
   logic [VEC_W-1:0] r_dsp_in;
   tag_t             r_tag [DSP_LAT+1];

   logic [M-1:0]     w_elig;
   logic [M-1:0]     w_grant;
   logic [IDX_W-1:0] w_win;
   logic             w_accept;
   tag_t             w_last;
   logic [M-1:0]     w_resp_take;

   // Reset also masks eligibility so req_ready stays low while rst is high
   assign w_elig      = bus.req_valid & ~r_slot_busy & {M{~rst}};
   assign w_resp_take = r_resp_valid & bus.resp_ready;
   assign w_last      = r_tag[DSP_LAT];

   // Every grant is taken in the same cycle (req_ready is the grant itself)
   rr_arbiter #(
      .WIDTH (M),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_req       (w_elig),
      .i_accept    (w_accept),
      .o_grant     (w_grant),
      .o_grant_idx (w_win),
      .o_any       (w_accept)
   );

   // Issue stage: load the winner's vector; dsp_in holds when nothing issues
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dsp_in <= '0;
         r_tag[0] <= TAG_IDLE;
      end else if (w_accept) begin
         r_dsp_in <= bus.req_data[w_win*VEC_W +: VEC_W];
         r_tag[0] <= '{valid: 1'b1, idx: w_win};
      end else begin
         r_tag[0] <= TAG_IDLE;
      end
   end

   // Tag delay line keeps the owner aligned with the engine output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 1; k <= DSP_LAT; k++) r_tag[k] <= TAG_IDLE;
      end else begin
         for (int k = 1; k <= DSP_LAT; k++) r_tag[k] <= r_tag[k-1];
      end
   end

   // Response holding registers: capture on tagged result, clear on take
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resp_valid <= '0;
         r_resp_data  <= '0;
      end else begin
         for (int i = 0; i < M; i++) begin
            if (w_last.valid && (w_last.idx == IDX_W'(i))) begin
               r_resp_valid[i]                <= 1'b1;
               r_resp_data[i*VEC_W +: VEC_W] <= bus.dsp_out;
            end else if (w_resp_take[i]) begin
               r_resp_valid[i] <= 1'b0;
            end
         end
      end
   end

   // One outstanding job per requester: busy from acceptance until its take
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot_busy <= '0;
      end else begin
         for (int i = 0; i < M; i++) begin
            if (w_grant[i])
               r_slot_busy[i] <= 1'b1;
            else if (w_resp_take[i])
               r_slot_busy[i] <= 1'b0;
         end
      end
   end

   assign bus.req_ready  = w_grant;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_data  = r_resp_data;
   assign bus.dsp_in     = r_dsp_in;
   assign bus.busy       = |r_slot_busy;

endmodule
`default_nettype wire
